// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the demux bit scheduler.
//   state_e     : FSM states (IDLE, SHIFT, GAP)
//   CH0..CH3    : destination channel codes
//   CNT_W       : width of each per-channel delivered-word counter
//   NUM_CH      : number of demux outputs
package demux_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam logic [1:0] CH0 = 2'd0;
  localparam logic [1:0] CH1 = 2'd1;
  localparam logic [1:0] CH2 = 2'd2;
  localparam logic [1:0] CH3 = 2'd3;

  localparam int CNT_W  = 8;
  localparam int NUM_CH = 4;

endpackage

// File: rtl/demux_chan_counter.sv
// Bank of four wrapping delivered-word counters, one per demux channel.
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset, clears all counters
//   inc      : increment the counter selected by ch this cycle
//   ch       : channel to increment
//   chan_cnt : flattened counters, channel n in bits [CNT_W*n +: CNT_W]
module demux_chan_counter
  import demux_sched_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    inc,
  input  logic [1:0]              ch,
  output logic [NUM_CH*CNT_W-1:0] chan_cnt
);

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[g] <= '0;
      end else if (inc && (ch == 2'(g))) begin
        // Natural modulo-2^CNT_W wrap.
        cnt_q[g] <= cnt_q[g] + 1'b1;
      end
    end
  end

  assign chan_cnt = cnt_q;

endmodule

// File: rtl/demux_bit_scheduler.sv
// Serialises destination-tagged words MSB-first onto a 1-to-4 demux input,
// holding the demux select stable for the whole word plus trailing gap.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : word to serialise          dest      : channel 0..3
//   din_valid  : din/dest valid             din_ready : accepting (IDLE only)
//   ser_out    : registered serial bit      s1, s0    : registered select
//   busy       : in SHIFT or GAP            done      : pulse after last bit
//   chan_cnt   : four 8-bit delivered-word counters, channel n at [8n+7:8n]
module demux_bit_scheduler
  import demux_sched_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int GAP    = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        dest,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              ser_out,
  output logic              s1,
  output logic              s0,
  output logic              busy,
  output logic              done,
  output logic [31:0]       chan_cnt
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  state_e            state_q;
  // Remaining (not yet emitted) bits, left-aligned so the next bit is the MSB.
  logic [DATA_W-1:0] shreg_q;
  logic [BW-1:0]     bit_cnt_q;
  logic [3:0]        gap_cnt_q;
  logic [1:0]        sel_q;
  logic              ser_q;
  logic              done_q;
  logic              last_bit;

  assign last_bit = (state_q == ST_SHIFT) && (bit_cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      sel_q     <= CH0;
      ser_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          ser_q <= 1'b0;
          if (din_valid) begin
            // MSB goes straight to the output register so it is on the
            // line in the first cycle after the handshake.
            ser_q     <= din[DATA_W-1];
            shreg_q   <= din << 1;
            sel_q     <= dest;
            bit_cnt_q <= BW'(DATA_W - 1);
            state_q   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (bit_cnt_q == '0) begin
            ser_q     <= 1'b0;
            done_q    <= 1'b1;
            gap_cnt_q <= 4'(GAP - 1);
            state_q   <= (GAP > 0) ? ST_GAP : ST_IDLE;
          end else begin
            ser_q     <= shreg_q[DATA_W-1];
            shreg_q   <= shreg_q << 1;
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        ST_GAP: begin
          ser_q <= 1'b0;
          if (gap_cnt_q == '0) state_q   <= ST_IDLE;
          else                 gap_cnt_q <= gap_cnt_q - 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Counter bumps on the same edge that raises done, using the held select.
  demux_chan_counter u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (last_bit),
    .ch       (sel_q),
    .chan_cnt (chan_cnt)
  );

  assign din_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign ser_out   = ser_q;
  assign s1        = sel_q[1];
  assign s0        = sel_q[0];
  assign done      = done_q;

endmodule

// File: tb/tb_demux_bit_scheduler.sv
module tb_demux_bit_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  din, din2;
  logic [1:0]  dest, dest2;
  logic        din_valid, din_valid2;
  logic        din_ready, ser_out, s1, s0, busy, done;
  logic        din_ready2, ser_out2, s1_2, s0_2, busy2, done2;
  logic [31:0] chan_cnt, chan_cnt2;

  int n_cmp = 0;
  int n_err = 0;
  int n_done = 0;
  int cyc = 0;

  demux_bit_scheduler #(.DATA_W(8), .GAP(1)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .dest(dest), .din_valid(din_valid),
    .din_ready(din_ready), .ser_out(ser_out), .s1(s1), .s0(s0),
    .busy(busy), .done(done), .chan_cnt(chan_cnt)
  );

  demux_bit_scheduler #(.DATA_W(8), .GAP(0)) dut_g0 (
    .clk(clk), .rst_n(rst_n), .din(din2), .dest(dest2), .din_valid(din_valid2),
    .din_ready(din_ready2), .ser_out(ser_out2), .s1(s1_2), .s0(s0_2),
    .busy(busy2), .done(done2), .chan_cnt(chan_cnt2)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done === 1'b1) n_done <= n_done + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  // Handshake one word, then watch its 8 bits; returns in the done cycle.
  task automatic send_word(input string tag, input logic [7:0] w, input logic [1:0] d,
                           input bit hold, input bit wiggle, output int hs);
    int n;
    int bad;
    logic [7:0] rx;
    din = w; dest = d; din_valid = 1'b1; n = 0;
    while (!din_ready && n < 50) begin tick; n++; end
    chk({tag, " ready"}, din_ready, 1);
    tick;
    hs = cyc;
    if (!hold) din_valid = 1'b0;
    rx = '0; bad = 0;
    for (int i = 0; i < 8; i++) begin
      rx = {rx[6:0], ser_out};
      if ({s1, s0} !== d || busy !== 1'b1 || done !== 1'b0 || din_ready !== 1'b0) bad++;
      if (wiggle) dest = ~dest;
      tick;
    end
    chk({tag, " data"}, rx, w);
    chk({tag, " sel/busy bad cycles"}, bad, 0);
    chk({tag, " done"}, done, 1);
    chk({tag, " sel in gap"}, {s1, s0}, d);
  endtask

  int hs, h0, h1, d0;
  int hsa[4];
  logic [7:0] wv[4];

  initial begin
    rst_n = 1'b1;
    din = '0; dest = '0; din_valid = 1'b0;
    din2 = '0; dest2 = '0; din_valid2 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst ser_out", ser_out, 0);
    chk("rst sel", {s1, s0}, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst chan_cnt", chan_cnt, 0);
    chk("rst din_ready", din_ready, 1);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // Single word A5 -> ch2
    send_word("a5", 8'hA5, 2'd2, 0, 0, hs);
    chk("a5 chan_cnt", chan_cnt, 32'h0001_0000);
    chk("a5 busy in gap", busy, 1);
    tick;
    chk("a5 ready after gap", din_ready, 1);
    chk("a5 busy after gap", busy, 0);
    chk("a5 done pulse width", done, 0);

    // Back-to-back, valid held high
    do_reset;
    wv[0] = 8'hFF; wv[1] = 8'h00; wv[2] = 8'h81; wv[3] = 8'h3C;
    for (int i = 0; i < 4; i++) send_word("b2b", wv[i], 2'(i), 1, 0, hsa[i]);
    din_valid = 1'b0;
    for (int i = 1; i < 4; i++) chk("b2b spacing", hsa[i] - hsa[i-1], 10);
    chk("b2b chan_cnt", chan_cnt, 32'h0101_0101);
    tick;

    // 256 words to ch1: wrap
    do_reset;
    d0 = n_done;
    for (int i = 0; i < 255; i++) send_word("wrap", 8'(i * 37), 2'd1, 1, 0, hs);
    chk("wrap cnt at 255", chan_cnt, 32'h0000_FF00);
    send_word("wrap", 8'h5B, 2'd1, 0, 0, hs);
    chk("wrap cnt at 256", chan_cnt, 32'h0000_0000);
    tick;
    chk("wrap done pulses", n_done - d0, 256);

    // Reset mid-word
    do_reset;
    d0 = n_done;
    din = 8'hC3; dest = 2'd3; din_valid = 1'b1;
    tick;
    din_valid = 1'b0;
    chk("abort bit7", ser_out, 1);
    tick; tick; tick;
    chk("abort busy before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort ser_out", ser_out, 0);
    chk("abort sel", {s1, s0}, 0);
    chk("abort busy", busy, 0);
    chk("abort ready", din_ready, 1);
    tick; tick; tick;
    chk("abort no done", n_done - d0, 0);
    chk("abort chan_cnt", chan_cnt, 0);
    rst_n = 1'b1;
    tick;
    send_word("post", 8'h5A, 2'd3, 0, 0, hs);
    chk("post chan_cnt", chan_cnt, 32'h0100_0000);
    tick;

    // dest wiggled while busy
    send_word("wig", 8'h96, 2'd1, 0, 1, hs);
    chk("wig chan_cnt", chan_cnt, 32'h0100_0100);
    tick;
    chk("wig sel held idle", {s1, s0}, 1);

    // GAP=0 instance, continuous valid
    din2 = 8'hFF; dest2 = 2'd1; din_valid2 = 1'b1;
    chk("g0 ready", din_ready2, 1);
    tick;
    h0 = cyc;
    chk("g0 bit7", ser_out2, 1);
    repeat (8) tick;
    chk("g0 idle ready", din_ready2, 1);
    chk("g0 idle ser_out", ser_out2, 0);
    chk("g0 done", done2, 1);
    chk("g0 idle busy", busy2, 0);
    tick;
    h1 = cyc;
    chk("g0 spacing", h1 - h0, 9);
    chk("g0 2nd bit7", ser_out2, 1);
    chk("g0 sel", {s1_2, s0_2}, 1);
    repeat (7) tick;
    din_valid2 = 1'b0;
    tick;
    chk("g0 chan_cnt", chan_cnt2, 32'h0000_0200);
    chk("g0 2nd done", done2, 1);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/demux_bit_scheduler.md
# demux_bit_scheduler

Upstream sequencer for the 1-to-4 bit demultiplexer. Accepts parallel words tagged with a 2-bit destination channel over a valid/ready handshake. Serialises each word MSB-first onto the demux data input. Holds the demux select lines stable for the whole word so that every bit lands on one output. Also keeps a per-channel delivered-word count.

## Interface
- `DATA_W`, default 8: word width in bits; legal range 2–16.
- `GAP`, default 1: idle cycles inserted after each word with select held and `ser_out`=0; legal range 0–15.
- Clock and reset are fixed: one clock (`clk`); reset is asynchronous and active-low (`rst_n`).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `din`  in  DATA_W  word to serialise.
- `dest`  in  2  destination channel, 0–3.
- `din_valid`  in  1  `din`/`dest` valid.
- `din_ready`  out  1  block can accept a word; high only in IDLE.
- `ser_out`  out  1  serial bit; drives the demux `in`.
- `s1`, `s0`  out  1 each  registered select; `{s1,s0}` equals the captured `dest`.
- `busy`  out  1  high in SHIFT or GAP.
- `done`  out  1  one-cycle pulse after the last bit of a word.
- `chan_cnt`  out  32  four 8-bit word counters; channel n occupies bits [8n+7:8n].

## Operation
- The FSM has three states: IDLE, SHIFT, GAP.
- IDLE
  - `din_ready`=1 and `ser_out`=0.
  - `s1`/`s0` hold their last value.
  - On `din_valid`&&`din_ready` at a rising edge: load `din` into the shift register, load `dest` into `{s1,s0}`, set `bit_cnt`=DATA_W-1, go to SHIFT.
- SHIFT
  - `ser_out` = shift-register MSB, registered.
  - Each cycle: shift left by one and decrement `bit_cnt`.
  - When `bit_cnt`=0: go to GAP if GAP>0, else IDLE.
  - On that same edge: set `done`, and increment `chan_cnt[dest]` by 1, modulo 256 (255 wraps to 0).
- GAP
  - `ser_out`=0, select held.
  - `gap_cnt` counts GAP cycles, then returns to IDLE.
- `dest` is sampled only on a handshake. `{s1,s0}` therefore never changes mid-word or mid-gap and never carries x/z. The demux must never see an undefined select.
- `din_valid` is ignored outside IDLE. No skid buffer: the source must hold `din`/`dest`/`din_valid` until a handshake occurs.
- `din_ready` is decoded from state, so it reads 1 while `rst_n` is low. Handshakes cannot complete during reset because no edges are acted on.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, `ser_out`=0, `s1`=`s0`=0, `busy`=0, `done`=0, `chan_cnt`=0, shift register=0.
  - `din_ready`=1.
- Handshake at edge k:
  - `{s1,s0}` is valid from cycle k+1.
  - Bit DATA_W-1 appears on `ser_out` in cycle k+1; bit 0 in cycle k+DATA_W.
  - `done`=1 and the counter has updated in cycle k+DATA_W+1.
- The first GAP cycle coincides with the `done` cycle. With GAP=0, IDLE is entered at that point.
- `din_ready` rises in cycle k+DATA_W+1+GAP. Peak throughput is one word per DATA_W+GAP+1 cycles.
- `busy` is high from cycle k+1 through the last GAP cycle.
- Reset asserted mid-word:
  - Transfer aborted, all outputs immediately at reset values.
  - No `done` pulse, no counter increment.
  - After release the block restarts in IDLE.
- Back-to-back words to different channels: the select changes only at the handshake edge, never while `busy`=1.

## Structure
- Package `demux_sched_pkg` holds:
  - the state typedef (IDLE, SHIFT, GAP);
  - channel constants CH0–CH3 = 2'd0–2'd3;
  - counter width constant CNT_W=8.
- One sub-module, `demux_chan_counter`: a bank of four CNT_W counters with inputs `clk`, `rst_n`, `inc`, `ch[1:0]`, and the flattened 32-bit output. The top-level block contains the FSM, shift register, `bit_cnt` and `gap_cnt`.

## Test plan
All scenarios use the default parameters (DATA_W=8, GAP=1) unless stated otherwise.
- Reset, then `din`=8'hA5, `dest`=2 → `ser_out` sequence 1,0,1,0,0,1,0,1 in cycles k+1..k+8; `{s1,s0}`=2'b10 throughout; `done` in k+9; `chan_cnt`=32'h0001_0000.
- `din_valid` held high with four words 8'hFF/ch0, 8'h00/ch1, 8'h81/ch2, 8'h3C/ch3 → `din_ready` high every 10 cycles; select changes only at handshake edges; `chan_cnt`=32'h0101_0101.
- 256 words to ch1 → ch1 count wraps to 0; other counters stay 0; exactly 256 `done` pulses.
- `rst_n` pulled low at bit 4 of 8'hC3/ch3 → outputs zero immediately; no `done`; `chan_cnt` unchanged (0); next word after release is delivered correctly.
- GAP=0 with continuous `din_valid` → one word per 9 cycles; `ser_out`=0 in the single IDLE cycle.
- `dest` toggled while `busy`=1 → `{s1,s0}` stable until the next handshake.
